// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: in-order WB writer (A) versus long-latency writer (B),
// with a busy scoreboard for outstanding B ops. Optional statistics via RF_ARB_STATS_EN.
module regfile_write_arbiter #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              b_alloc,
    input  logic [ADDR_W-1:0] b_alloc_rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              hazard,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wdata
`ifdef RF_ARB_STATS_EN
    ,
    output logic [31:0]       stat_force,
    output logic [31:0]       stat_astall
`endif
);

    localparam int          NREG       = 1 << ADDR_W;
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] X0   = {ADDR_W{1'b0}};

    logic [3:0]        starve_q, starve_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              force_b_s, grant_a_s, grant_b_s;

    // Grant selection: A has priority unless B has waited STARVE_MAX cycles.
    always_comb begin
        force_b_s = (starve_q == STARVE_LIM);
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (a_valid && b_valid) begin
            grant_a_s = !force_b_s;
            grant_b_s = force_b_s;
        end else begin
            grant_a_s = a_valid;
            grant_b_s = b_valid;
        end
    end

    assign a_ready = grant_a_s & reset;
    assign b_ready = grant_b_s & reset;
    assign hazard  = busy_q[rs1] | busy_q[rs2] | (a_valid & busy_q[a_rd]);

    // Next-state for starvation counter, scoreboard and write-port pipeline.
    always_comb begin
        starve_d = starve_q;
        if (grant_b_s) begin
            starve_d = 4'd0;
        end else if (b_valid && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end

        // A fresh allocation beats the completing write to the same register.
        busy_d = busy_q;
        for (int i = 0; i < NREG; i++) begin
            busy_d[i] = (b_alloc && (b_alloc_rd == ADDR_W'(i)))
                      | (busy_q[i] & ~(grant_b_s && (b_rd == ADDR_W'(i))));
        end
        busy_d[0] = 1'b0;

        we_d   = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        if (grant_a_s && (a_rd != X0)) begin
            we_d   = 1'b1;
            rd_d   = a_rd;
            data_d = a_data;
        end else if (grant_b_s && (b_rd != X0)) begin
            we_d   = 1'b1;
            rd_d   = b_rd;
            data_d = b_data;
        end else begin
            we_d   = 1'b0;
        end
    end

    // State registers; reset also drops any pending write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= 4'd0;
            busy_q   <= {NREG{1'b0}};
            we_q     <= 1'b0;
            rd_q     <= X0;
            data_q   <= {DATA_W{1'b0}};
        end else begin
            starve_q <= starve_d;
            busy_q   <= busy_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
        end
    end

    assign rf_we    = we_q;
    assign rf_rd    = rd_q;
    assign rf_wdata = data_q;

`ifdef RF_ARB_STATS_EN
    logic [31:0] force_cnt_q, astall_cnt_q;

    // Statistics: forced B grants and cycles where WB was held off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            force_cnt_q  <= 32'd0;
            astall_cnt_q <= 32'd0;
        end else begin
            if (grant_b_s && a_valid) begin
                force_cnt_q <= force_cnt_q + 32'd1;
            end else begin
                force_cnt_q <= force_cnt_q;
            end
            if (a_valid && !grant_a_s) begin
                astall_cnt_q <= astall_cnt_q + 32'd1;
            end else begin
                astall_cnt_q <= astall_cnt_q;
            end
        end
    end

    assign stat_force  = force_cnt_q;
    assign stat_astall = astall_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes queued at grant, checked one edge later.
module tb_regfile_write_arbiter;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_valid, b_valid, b_alloc;
    logic [AW-1:0] a_rd, b_rd, b_alloc_rd, rs1, rs2;
    logic [DW-1:0] a_data, b_data;
    logic          a_ready, b_ready, hazard, rf_we;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_wdata;
`ifdef RF_ARB_STATS_EN
    logic [31:0]   stat_force, stat_astall;
`endif

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .b_alloc(b_alloc), .b_alloc_rd(b_alloc_rd),
        .rs1(rs1), .rs2(rs2), .hazard(hazard),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
`ifdef RF_ARB_STATS_EN
        , .stat_force(stat_force), .stat_astall(stat_astall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            m_starve;
    logic [31:0]   m_busy;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_data;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_starve = 0;
        m_busy   = 32'd0;
        m_rd     = '0;
        m_data   = '0;
        exp_q.delete();
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        b_alloc = 1'b0; b_alloc_rd = '0;
        rs1 = '0; rs2 = '0;
    endtask

    // One clock cycle: check combinational outputs, queue expected write, check it after the edge.
    task automatic cyc();
        logic fa, ga, gb, hz;
        wr_t  e;
        #1;
        fa = (m_starve == SM);
        ga = a_valid && (!b_valid || !fa);
        gb = b_valid && (!a_valid || fa);
        hz = m_busy[rs1] | m_busy[rs2] | (a_valid & m_busy[a_rd]);
        check_val("a_ready", 64'(a_ready), 64'(ga));
        check_val("b_ready", 64'(b_ready), 64'(gb));
        check_val("hazard", 64'(hazard), 64'(hz));
        e = {1'b0, m_rd, m_data};
        if (ga && a_rd != '0)      e = {1'b1, a_rd, a_data};
        else if (gb && b_rd != '0) e = {1'b1, b_rd, b_data};
        exp_q.push_back(e);
        m_rd   = e.rd;
        m_data = e.data;
        if (gb) m_starve = 0;
        else if (b_valid && m_starve < SM) m_starve++;
        if (gb) m_busy[b_rd] = 1'b0;
        if (b_alloc && b_alloc_rd != '0) m_busy[b_alloc_rd] = 1'b1;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val("queue_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check_val("rf_we", 64'(rf_we), 64'(e.we));
            check_val("rf_rd", 64'(rf_rd), 64'(e.rd));
            check_val("rf_wdata", rf_wdata, e.data);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        // Reset held with a pending WB request
        a_valid = 1'b1; a_rd = 5'd5; a_data = 64'hAA;
        #1;
        check_val("rst_rf_we", 64'(rf_we), 64'd0);
        check_val("rst_a_ready", 64'(a_ready), 64'd0);
        check_val("rst_hazard", 64'(hazard), 64'd0);
        check_val("rst_rf_rd", 64'(rf_rd), 64'd0);
        check_val("rst_rf_wdata", rf_wdata, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc();   // A only: rd 5 data AA
        check_val("a_only_we", 64'(rf_we), 64'd1);
        check_val("a_only_rd", 64'(rf_rd), 64'd5);
        check_val("a_only_data", rf_wdata, 64'hAA);

        // Starvation: both valid continuously; B must win on the fifth cycle only
        for (int i = 0; i < 7; i++) begin
            a_valid = 1'b1; a_rd = 5'd3; a_data = 64'(100 + i);
            b_valid = 1'b1; b_rd = 5'd4; b_data = 64'(200 + i);
            #1;
            check_val("starve_b_ready", 64'(b_ready), (i == 4) ? 64'd1 : 64'd0);
            #1;
            cyc();
        end
        idle_inputs();

        // Scoreboard set / clear / same-cycle set-wins
        b_alloc = 1'b1; b_alloc_rd = 5'd7; cyc();
        b_alloc = 1'b0; rs1 = 5'd7; cyc();
        check_val("busy7_hazard", 64'(hazard), 64'd1);
        b_valid = 1'b1; b_rd = 5'd7; b_data = 64'h77; cyc();
        b_valid = 1'b0; cyc();
        check_val("busy7_cleared", 64'(hazard), 64'd0);
        b_alloc = 1'b1; b_alloc_rd = 5'd7; cyc();
        b_valid = 1'b1; b_rd = 5'd7; b_data = 64'h78; cyc();
        b_alloc = 1'b0; b_valid = 1'b0; rs1 = '0; rs2 = 5'd7; cyc();
        check_val("setwins_hazard", 64'(hazard), 64'd1);
        rs2 = '0; a_valid = 1'b1; a_rd = 5'd7; a_data = 64'h55; cyc();   // WAW: still granted, hazard flagged
        idle_inputs();

        // x0 writes and allocations
        a_valid = 1'b1; a_rd = '0; a_data = 64'hDEAD; cyc();
        check_val("x0_we", 64'(rf_we), 64'd0);
        a_valid = 1'b0; b_alloc = 1'b1; b_alloc_rd = '0; rs1 = '0; cyc();
        b_alloc = 1'b0; cyc();
        check_val("x0_alloc_hazard", 64'(hazard), 64'd0);

        // Async reset between grant and next edge with a write in flight
        rs1 = 5'd7; a_valid = 1'b1; a_rd = 5'd9; a_data = 64'h99; cyc();
        check_val("pre_rst_we", 64'(rf_we), 64'd1);
        a_rd = 5'd11; a_data = 64'hBB;
        #2;
        reset = 1'b0;
        #1;
        check_val("midrst_we", 64'(rf_we), 64'd0);
        check_val("midrst_hazard", 64'(hazard), 64'd0);
        check_val("midrst_a_ready", 64'(a_ready), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_val("midrst_we_after_edge", 64'(rf_we), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();

        // Random traffic over a small register window
        for (int i = 0; i < 60; i++) begin
            a_valid    = 1'($urandom_range(0, 1));
            a_rd       = AW'($urandom_range(0, 7));
            a_data     = {$urandom, $urandom};
            b_valid    = 1'($urandom_range(0, 3) != 0);
            b_rd       = AW'($urandom_range(0, 7));
            b_data     = {$urandom, $urandom};
            b_alloc    = 1'($urandom_range(0, 1));
            b_alloc_rd = AW'($urandom_range(0, 7));
            rs1        = AW'($urandom_range(0, 7));
            rs2        = AW'($urandom_range(0, 7));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
